pipe_hazard_sequencer: RTL and testbench

- Central pipeline-control sequencer for the 5-stage MIPS core, covering F/D/E/M/W.
- Merges three sources into one set of stage enables and clears:
  - the data-hazard stall request;
  - a multi-cycle mult/div busy tracker (owns the HI/LO unit occupancy counter);
  - exception/interrupt and eret flush requests from CP0.
- Sits between the hazard detector, the CP0 and the PC/pipeline registers.

---
 rtl/pipe_hazard_sequencer.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sequencer.sv
// pipe_hazard_sequencer
// Central pipeline-control sequencer for the 5-stage MIPS core (F/D/E/M/W).
// Merges the data-hazard stall, the multi-cycle mult/div occupancy tracker
// and CP0 exception/eret flush requests into one set of stage controls.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   Stall_Data         load-use/forwarding stall (X/Z treated as 0)
//   E_MD_Start         E stage holds a valid mult/multu/div/divu
//   E_MD_Type          0 = mult class, 1 = div class
//   D_MD_Use           D stage instruction needs the MD unit
//   Exc_Req, Eret_Req  CP0 exception / eret flush on the M-stage instruction
//   PC_En, D_En        PC and F/D register enables
//   D_Clr, E_Clr, M_Clr  F/D, D/E, E/M register clears
//   PC_Sel_Exc         PC loads handler address 0x00004180
//   PC_Sel_Epc         PC loads EPC
//   MD_Busy            MD unit occupied (registered)
//   MD_Done            one-cycle registered pulse when the MD result is valid
//   Stall_Cnt          (HAZ_STALL_COUNT_EN only) saturating count of stall cycles
//
// Optional feature macro: HAZ_STALL_COUNT_EN
module pipe_hazard_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic Stall_Data,
  input  logic E_MD_Start,
  input  logic E_MD_Type,
  input  logic D_MD_Use,
  input  logic Exc_Req,
  input  logic Eret_Req,
  output logic PC_En,
  output logic D_En,
  output logic D_Clr,
  output logic E_Clr,
  output logic M_Clr,
  output logic PC_Sel_Exc,
  output logic PC_Sel_Epc,
  output logic MD_Busy,
  output logic MD_Done
`ifdef HAZ_STALL_COUNT_EN
  ,
  output logic [31:0] Stall_Cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic start_acc;
  logic stall_data;
  logic stall_md;
  logic stall;

  // A start alongside an M-stage flush belongs to a squashed instruction.
  assign start_acc = E_MD_Start & ~Exc_Req & ~Eret_Req & (state_q == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Flushes never cancel a running operation; a start while BUSY is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start_acc) begin
        state_d = BUSY;
        cnt_d   = E_MD_Type ? DIV_LD : MULT_LD;
      end
    end else begin
      if (cnt_q == CNT_ONE) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  assign MD_Busy = (state_q == BUSY);
  assign MD_Done = done_q;

  // Stall_Data is compared with === so an unknown request does not stall.
  assign stall_data = (Stall_Data === 1'b1);
  assign stall_md   = D_MD_Use & (MD_Busy | E_MD_Start);
  assign stall      = stall_data | stall_md;

  always_comb begin
    PC_En      = 1'b1;
    D_En       = 1'b1;
    D_Clr      = 1'b0;
    E_Clr      = 1'b0;
    M_Clr      = 1'b0;
    PC_Sel_Exc = 1'b0;
    PC_Sel_Epc = 1'b0;
    if (!reset) begin
      if (Exc_Req || Eret_Req) begin
        D_Clr      = 1'b1;
        E_Clr      = 1'b1;
        M_Clr      = 1'b1;
        PC_Sel_Exc = Exc_Req;
        PC_Sel_Epc = ~Exc_Req;
      end else if (stall) begin
        PC_En = 1'b0;
        D_En  = 1'b0;
        E_Clr = 1'b1;
      end
    end
  end

`ifdef HAZ_STALL_COUNT_EN
  logic [31:0] scnt_q, scnt_d;
  logic        stall_case;

  assign stall_case = stall & ~Exc_Req & ~Eret_Req;

  always_comb begin
    scnt_d = scnt_q;
    if (stall_case && (scnt_q != '1)) begin
      scnt_d = scnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
    end
  end

  assign Stall_Cnt = scnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Self-checking bench for pipe_hazard_sequencer: constant vector table,
// hand-written multi-cycle sequences and randomized stimulus against a
// cycle-count reference model.
module tb_pipe_hazard_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic Stall_Data, E_MD_Start, E_MD_Type, D_MD_Use, Exc_Req, Eret_Req;
  logic PC_En, D_En, D_Clr, E_Clr, M_Clr, PC_Sel_Exc, PC_Sel_Epc, MD_Busy, MD_Done;
`ifdef HAZ_STALL_COUNT_EN
  logic [31:0] Stall_Cnt;
`endif

  pipe_hazard_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(rst),
    .Stall_Data(Stall_Data), .E_MD_Start(E_MD_Start), .E_MD_Type(E_MD_Type),
    .D_MD_Use(D_MD_Use), .Exc_Req(Exc_Req), .Eret_Req(Eret_Req),
    .PC_En(PC_En), .D_En(D_En), .D_Clr(D_Clr), .E_Clr(E_Clr), .M_Clr(M_Clr),
    .PC_Sel_Exc(PC_Sel_Exc), .PC_Sel_Epc(PC_Sel_Epc),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done)
`ifdef HAZ_STALL_COUNT_EN
    , .Stall_Cnt(Stall_Cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining busy cycles, pending done pulse, stall count.
  int          m_rem  = 0;
  bit          m_done = 1'b0;
  longint      m_scnt = 0;

  logic obs_pc, obs_busy, obs_done;

  typedef struct {
    logic [5:0] in;   // {sd, start, type, use, exc, eret}
    logic [6:0] exp;  // {pc_en, d_en, d_clr, e_clr, m_clr, sel_exc, sel_epc}
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_done = 1'b0; m_scnt = 0;
  endtask

  function automatic logic [6:0] exp_ctrl();
    bit stall;
    stall = Stall_Data | (D_MD_Use & ((m_rem > 0) | E_MD_Start));
    if (rst)           return 7'b1100000;
    if (Exc_Req)       return 7'b1111110;
    if (Eret_Req)      return 7'b1111101;
    if (stall)         return 7'b0001000;
    return 7'b1100000;
  endfunction

  task automatic check_all();
    logic [6:0] e;
    e = exp_ctrl();
    chk("PC_En",      PC_En,      e[6]);
    chk("D_En",       D_En,       e[5]);
    chk("D_Clr",      D_Clr,      e[4]);
    chk("E_Clr",      E_Clr,      e[3]);
    chk("M_Clr",      M_Clr,      e[2]);
    chk("PC_Sel_Exc", PC_Sel_Exc, e[1]);
    chk("PC_Sel_Epc", PC_Sel_Epc, e[0]);
    chk("MD_Busy",    MD_Busy,    (m_rem > 0));
    chk("MD_Done",    MD_Done,    m_done);
`ifdef HAZ_STALL_COUNT_EN
    chk("Stall_Cnt",  Stall_Cnt,  m_scnt);
`endif
    obs_pc = PC_En; obs_busy = MD_Busy; obs_done = MD_Done;
  endtask

  // Called right after a rising edge, with the inputs that were held across it.
  task automatic model_step();
    bit stall;
    if (rst) begin
      model_reset();
      return;
    end
    stall = Stall_Data | (D_MD_Use & ((m_rem > 0) | E_MD_Start));
    if (stall && !Exc_Req && !Eret_Req && m_scnt < 64'hFFFF_FFFF) m_scnt++;
    m_done = (m_rem == 1);
    if (m_rem > 0) m_rem--;
    else if (E_MD_Start && !Exc_Req && !Eret_Req) m_rem = E_MD_Type ? 10 : 5;
  endtask

  task automatic drive(input logic sd, st, ty, us, ex, er);
    Stall_Data = sd; E_MD_Start = st; E_MD_Type = ty;
    D_MD_Use = us; Exc_Req = ex; Eret_Req = er;
  endtask

  // One cycle: entered just after a rising edge.
  task automatic cyc(input logic sd, st, ty, us, ex, er);
    drive(sd, st, ty, us, ex, er);
    #2;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", MD_Busy, 0);
    chk("async_rst_done", MD_Done, 0);
    chk("async_rst_pcen", PC_En, 1);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int busy_n, stall_n, done_n, last_busy, first_done;

    vecs[0] = '{6'b000000, 7'b1100000};
    vecs[1] = '{6'b100000, 7'b0001000};
    vecs[2] = '{6'b010100, 7'b0001000};
    vecs[3] = '{6'b011000, 7'b1100000};
    vecs[4] = '{6'b000100, 7'b1100000};
    vecs[5] = '{6'b010010, 7'b1111110};
    vecs[6] = '{6'b100011, 7'b1111110};
    vecs[7] = '{6'b100101, 7'b1111101};
    vecs[8] = '{6'b010101, 7'b1111101};

    rst = 1'b1;
    drive(1, 0, 0, 1, 0, 0);
    #2;
    chk("rst_PC_En", PC_En, 1);
    chk("rst_D_En", D_En, 1);
    chk("rst_E_Clr", E_Clr, 0);
    chk("rst_MD_Busy", MD_Busy, 0);
    chk("rst_MD_Done", MD_Done, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Combinational vector table, each applied from IDLE.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].in[5], vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
      #1;
      chk($sformatf("vec%0d", i),
          {PC_En, D_En, D_Clr, E_Clr, M_Clr, PC_Sel_Exc, PC_Sel_Epc}, vecs[i].exp);
      drive(0, 0, 0, 0, 0, 0);
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      model_reset();
    end
    @(posedge clk); #1;

    // Single-cycle data stall.
    cyc(1, 0, 0, 0, 0, 0);
    chk("sd_stall_pc", obs_pc, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sd_release_pc", obs_pc, 1);

    // mult with D_MD_Use held.
    busy_n = 0; stall_n = 0; done_n = 0; last_busy = -1; first_done = -1;
    cyc(0, 1, 0, 1, 0, 0);
    if (!obs_pc) stall_n++;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      if (obs_busy) begin busy_n++; last_busy = i; end
      if (!obs_pc) stall_n++;
      if (obs_done) begin done_n++; if (first_done < 0) first_done = i; end
    end
    chk("mult_busy_cycles", busy_n, 5);
    chk("mult_stall_cycles", stall_n, 6);
    chk("mult_done_pulses", done_n, 1);
    chk("mult_done_timing", first_done, last_busy + 1);

    // div with a second start at busy cycle 4.
    busy_n = 0;
    cyc(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      cyc(0, (i == 3), 0, 0, 0, 0);
      if (obs_busy) busy_n++;
    end
    chk("div_restart_busy_cycles", busy_n, 10);

    // Start squashed by an exception.
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("squashed_start_busy", obs_busy, 0);

    // Exception during div busy does not cancel.
    busy_n = 0;
    cyc(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      cyc(0, 0, 0, 0, (i == 2), (i == 5));
      if (obs_busy) busy_n++;
    end
    chk("div_exc_busy_cycles", busy_n, 10);

    // Async reset mid-mult (busy cycle 2).
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    async_reset_pulse();
    @(posedge clk); model_step(); #1;
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (obs_done) done_n++;
      if (obs_busy) busy_n++;
    end
    chk("post_rst_done", done_n, 0);
    chk("post_rst_busy", busy_n, 0);

`ifdef HAZ_STALL_COUNT_EN
    drive(0, 0, 0, 0, 0, 0);
    async_reset_pulse();
    @(posedge clk); model_step(); #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    async_reset_pulse();
    @(posedge clk); model_step(); #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_cnt_3", Stall_Cnt, 3);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
          1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
